// File: rtl/ddr_app_ctrl_if.sv
// User-side request/response channel of the DDR application controller.
// The master modport is the requester; the slave modport is the controller.
interface ddr_app_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [27:0]  req_addr;
  logic [511:0] req_wdata;
  logic [63:0]  req_wmask;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [511:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ddr_app_ctrl.sv
// Single-request bridge from a valid/ready user channel onto the MIG app_* interface,
// with read-credit tracking and a first-word fall-through read-return FIFO.
module ddr_app_ctrl #(
  parameter int unsigned RD_DEPTH = 16
) (
  input  logic          ui_clk,
  input  logic          ui_rst_n,
  input  logic          init_calib_complete,
  ddr_app_ctrl_if.slave usr,
  output logic [27:0]   app_addr,
  output logic [2:0]    app_cmd,
  output logic          app_en,
  output logic [511:0]  app_wdf_data,
  output logic [63:0]   app_wdf_mask,
  output logic          app_wdf_wren,
  output logic          app_wdf_end,
  input  logic          app_rdy,
  input  logic          app_wdf_rdy,
  input  logic          app_rd_data_valid,
  input  logic          app_rd_data_end,
  input  logic [511:0]  app_rd_data,
  output logic          busy,
  output logic          rd_overflow
);
  localparam int unsigned AW      = $clog2(RD_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(RD_DEPTH);
  localparam logic [2:0]  CMD_WR  = 3'b000;
  localparam logic [2:0]  CMD_RD  = 3'b001;

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_e;

  state_e         state_q, state_d;
  logic [27:0]    addr_q, addr_d;
  logic [2:0]     cmd_q, cmd_d;
  logic           en_q, en_d;
  logic [511:0]   wdata_q, wdata_d;
  logic [63:0]    wmask_q, wmask_d;
  logic           wren_q, wren_d;
  logic           wend_q, wend_d;
  logic           cmd_done_q, cmd_done_d;
  logic           data_done_q, data_done_d;
  logic [AW:0]    inflight_q, inflight_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [511:0]   mem_q [RD_DEPTH];

  logic req_ready;
  logic rsp_valid;
  logic rd_accept;
  logic pop;
  logic push;
  logic full;
  logic unused_rd_end;

  assign unused_rd_end = app_rd_data_end;

  assign req_ready     = (state_q == IDLE) && (inflight_q < DEPTH_C);
  assign rsp_valid     = (count_q != '0);
  assign full          = (count_q == DEPTH_C);
  assign pop           = rsp_valid && usr.rsp_ready;
  // A pop frees the head slot this cycle, so a full FIFO can still take a push.
  assign push          = app_rd_data_valid && (!full || pop);
  assign rd_accept     = en_q && app_rdy && (cmd_q == CMD_RD);

  assign usr.req_ready = req_ready;
  assign usr.rsp_valid = rsp_valid;
  assign usr.rsp_data  = mem_q[rd_ptr_q];

  assign app_addr      = addr_q;
  assign app_cmd       = cmd_q;
  assign app_en        = en_q;
  assign app_wdf_data  = wdata_q;
  assign app_wdf_mask  = wmask_q;
  assign app_wdf_wren  = wren_q;
  assign app_wdf_end   = wend_q;
  // WAIT_CAL reads as not busy so that reset presents busy=0.
  assign busy          = (state_q == ISSUE);
  assign rd_overflow   = ovf_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    en_d        = en_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    wren_d      = wren_q;
    wend_d      = wend_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    unique case (state_q)
      WAIT_CAL: begin
        if (init_calib_complete) state_d = IDLE;
      end
      IDLE: begin
        if (usr.req_valid && req_ready) begin
          state_d    = ISSUE;
          addr_d     = usr.req_addr;
          cmd_d      = usr.req_write ? CMD_WR : CMD_RD;
          en_d       = 1'b1;
          cmd_done_d = 1'b0;
          if (usr.req_write) begin
            wdata_d     = usr.req_wdata;
            wmask_d     = usr.req_wmask;
            wren_d      = 1'b1;
            wend_d      = 1'b1;
            data_done_d = 1'b0;
          end else begin
            data_done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cmd_done_q && data_done_q) state_d = IDLE;
        if (en_q && app_rdy) begin
          en_d       = 1'b0;
          cmd_done_d = 1'b1;
        end
        if (wren_q && app_wdf_rdy) begin
          wren_d      = 1'b0;
          wend_d      = 1'b0;
          data_done_d = 1'b1;
        end
      end
      default: state_d = WAIT_CAL;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_accept && !pop)      inflight_d = inflight_q + 1'b1;
    else if (!rd_accept && pop) inflight_d = inflight_q - 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    ovf_d = ovf_q || (app_rd_data_valid && !push);
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state_q     <= WAIT_CAL;
      addr_q      <= '0;
      cmd_q       <= '0;
      en_q        <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wren_q      <= 1'b0;
      wend_q      <= 1'b0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      wren_q      <= wren_d;
      wend_q      <= wend_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (push) mem_q[wr_ptr_q] <= app_rd_data;
  end
endmodule
